// File: rtl/uart_mult_byte_tx_pkg.sv
// Shared definitions for the multi-byte UART frame transmitter:
// frame header bytes, CRC8 constants, FSM state encoding and a CRC helper.
package uart_mult_byte_tx_pkg;

    localparam logic [7:0] UART_HEAD0 = 8'h55;
    localparam logic [7:0] UART_HEAD1 = 8'hAA;
    localparam logic [7:0] CRC8_POLY  = 8'h07;
    localparam logic [7:0] CRC8_INIT  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAD0   = 3'd1,
        ST_HEAD1   = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CRC     = 3'd5,
        ST_DONE    = 3'd6
    } tx_state_t;

    // One byte of CRC8 (no reflection, no final XOR), folded into a running value
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_mult_byte_tx_byte.sv
// Single-byte 8N1 serialiser: start bit, d0..d7 LSB first, stop bit, then an
// optional run of idle-high bit periods. o_done is high during the final cycle
// of the byte so the sequencer can chain the next byte with no dead cycle; a
// start in that cycle takes priority over returning to idle.
module uart_mult_byte_tx_byte #(
    parameter int BPS_CNT  = 434,
    parameter int GAP_BITS = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_gap,
    output logic       o_txd,
    output logic       o_done
);

    localparam int BAUD_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    logic [BAUD_W-1:0] r_baud_cnt;
    logic [7:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_busy;
    logic              r_gap;
    logic              r_txd;

    logic              w_baud_end;
    logic [7:0]        w_last_bit;

    assign w_baud_end = (r_baud_cnt == BAUD_W'(BPS_CNT - 1));
    assign w_last_bit = r_gap ? 8'(9 + GAP_BITS) : 8'd9;
    assign o_done     = r_busy & w_baud_end & (r_bit_cnt == w_last_bit);
    assign o_txd      = r_txd;

    // Baud/bit counters and the registered line driver; bit 0 is the start bit,
    // bits 1..8 are data, bit 9 is stop and anything beyond is idle gap
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 8'd0;
            r_shift    <= 8'd0;
            r_busy     <= 1'b0;
            r_gap      <= 1'b0;
            r_txd      <= 1'b1;
        end else if (i_start) begin
            r_shift    <= i_data;
            r_gap      <= i_gap;
            r_busy     <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 8'd0;
            r_txd      <= 1'b0;
        end else if (r_busy) begin
            if (w_baud_end) begin
                r_baud_cnt <= '0;
                if (o_done) begin
                    r_busy    <= 1'b0;
                    r_bit_cnt <= 8'd0;
                    r_txd     <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    if (r_bit_cnt < 8'd8) begin
                        r_txd <= r_shift[r_bit_cnt[2:0]];
                    end else begin
                        r_txd <= 1'b1;
                    end
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: HEAD0, HEAD1, LEN, payload, CRC8.
// The FSM sequences bytes into the single-byte serialiser, holds a shadow copy
// of the payload taken at start, and folds LEN and payload into the CRC as each
// byte is handed to the serialiser so the CRC is ready when its turn comes.
module uart_mult_byte_tx
    import uart_mult_byte_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int MAX_BYTES = 12,
    parameter int BYTE_GAP  = 0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   tx_start,
    input  logic [7:0]             tx_len,
    input  logic [MAX_BYTES*8-1:0] tx_data,
    output logic                   uart_txd,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [7:0]             byte_idx
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic [MAX_BYTES*8-1:0] r_data;
    logic [7:0]             r_len;
    logic [7:0]             r_pidx;
    logic [7:0]             r_crc;
    logic [7:0]             r_byte_idx;

    logic [7:0]             w_len_clamped;
    logic [7:0]             w_sel_idx;
    logic [7:0]             w_sel_byte;
    logic                   w_load;
    logic [7:0]             w_load_byte;
    logic                   w_gap;
    logic [7:0]             w_next_pidx;
    logic [7:0]             w_crc_next;
    logic                   w_byte_done;
    logic                   w_txd;

    assign w_len_clamped = (tx_len > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : tx_len;
    assign w_sel_idx     = (r_state == ST_LEN) ? 8'd0 : (r_pidx + 8'd1);

    // Pick the payload byte that will be sent next out of the shadow register
    always_comb begin
        w_sel_byte = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (w_sel_idx == 8'(k)) begin
                w_sel_byte = r_data[8*k +: 8];
            end
        end
    end

    // Next-state logic: each state is the byte on the line; when it finishes,
    // the following byte is loaded in the same cycle and the CRC advances
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_byte  = 8'h00;
        w_gap        = 1'b1;
        w_next_pidx  = r_pidx;
        w_crc_next   = r_crc;
        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_load       = 1'b1;
                    w_load_byte  = UART_HEAD0;
                    w_crc_next   = CRC8_INIT;
                    w_next_state = ST_HEAD0;
                end
            end
            ST_HEAD0: begin
                if (w_byte_done) begin
                    w_load       = 1'b1;
                    w_load_byte  = UART_HEAD1;
                    w_next_state = ST_HEAD1;
                end
            end
            ST_HEAD1: begin
                if (w_byte_done) begin
                    w_load       = 1'b1;
                    w_load_byte  = r_len;
                    w_crc_next   = crc8_update(CRC8_INIT, r_len);
                    w_next_state = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_byte_done) begin
                    w_load = 1'b1;
                    if (r_len == 8'd0) begin
                        w_load_byte  = r_crc;
                        w_gap        = 1'b0;
                        w_next_state = ST_CRC;
                    end else begin
                        w_load_byte  = w_sel_byte;
                        w_crc_next   = crc8_update(r_crc, w_sel_byte);
                        w_next_pidx  = 8'd0;
                        w_next_state = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_byte_done) begin
                    w_load = 1'b1;
                    if (r_pidx == (r_len - 8'd1)) begin
                        w_load_byte  = r_crc;
                        w_gap        = 1'b0;
                        w_next_state = ST_CRC;
                    end else begin
                        w_load_byte = w_sel_byte;
                        w_crc_next  = crc8_update(r_crc, w_sel_byte);
                        w_next_pidx = r_pidx + 8'd1;
                    end
                end
            end
            ST_CRC: begin
                if (w_byte_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, CRC, payload index and the shadow copy taken only when idle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_len      <= 8'd0;
            r_pidx     <= 8'd0;
            r_crc      <= CRC8_INIT;
            r_byte_idx <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_pidx  <= w_next_pidx;
            r_crc   <= w_crc_next;
            if (r_state == ST_IDLE && tx_start) begin
                r_data <= tx_data;
                r_len  <= w_len_clamped;
            end
            if (r_state == ST_DONE) begin
                r_byte_idx <= 8'd0;
            end else if (w_load) begin
                r_byte_idx <= (r_state == ST_IDLE) ? 8'd0 : (r_byte_idx + 8'd1);
            end
        end
    end

    uart_mult_byte_tx_byte #(
        .BPS_CNT  (BPS_CNT),
        .GAP_BITS (BYTE_GAP)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_start   (w_load),
        .i_data    (w_load_byte),
        .i_gap     (w_gap),
        .o_txd     (w_txd),
        .o_done    (w_byte_done)
    );

    assign uart_txd = w_txd;
    assign tx_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign tx_done  = (r_state == ST_DONE);
    assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: two instances (no byte gap / one-bit gap),
// a cycle-accurate UART line decoder per instance and a byte scoreboard.
module tb_uart_mult_byte_tx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int MB       = 12;

    typedef struct {
        logic [7:0] b;
        int         gap;
        bit         last;
    } expItem_t;

    logic             sysClk = 1'b0;
    logic             sysRstN = 1'b0;
    logic             txStart [2];
    logic [7:0]       txLen   [2];
    logic [MB*8-1:0]  txData  [2];
    logic             uartTxd [2];
    logic             txBusy  [2];
    logic             txDone  [2];
    logic [7:0]       byteIdx [2];

    int checks = 0;
    int errors = 0;

    expItem_t expQ0[$];
    expItem_t expQ1[$];
    int doneCnt[2];

    int         dState  [2];
    int         cyc     [2];
    int         bitIdx  [2];
    logic       bitVal  [2];
    logic [7:0] rxByte  [2];
    logic       stopVal [2];
    bit         widthOk [2];
    int         gapCnt  [2];
    int         curGap  [2];

    always #5 sysClk = ~sysClk;

    uart_mult_byte_tx #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .MAX_BYTES(MB), .BYTE_GAP(0)
    ) dut0 (
        .sys_clk(sysClk), .sys_rst_n(sysRstN), .tx_start(txStart[0]), .tx_len(txLen[0]),
        .tx_data(txData[0]), .uart_txd(uartTxd[0]), .tx_busy(txBusy[0]), .tx_done(txDone[0]),
        .byte_idx(byteIdx[0])
    );

    uart_mult_byte_tx #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .MAX_BYTES(MB), .BYTE_GAP(1)
    ) dut1 (
        .sys_clk(sysClk), .sys_rst_n(sysRstN), .tx_start(txStart[1]), .tx_len(txLen[1]),
        .tx_data(txData[1]), .uart_txd(uartTxd[1]), .tx_busy(txBusy[1]), .tx_done(txDone[1]),
        .byte_idx(byteIdx[1])
    );

    // Reference CRC8 (poly 0x07), bit-serial MSB-first long division
    function automatic logic [7:0] crcModel(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        logic fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic pushExp(input int d, input logic [7:0] b, input int gap, input bit last);
        expItem_t it;
        it.b = b;
        it.gap = gap;
        it.last = last;
        if (d == 0) expQ0.push_back(it);
        else expQ1.push_back(it);
    endtask

    // A decoded byte has just ended: compare it with the head of the scoreboard
    task automatic finishByte(input int d);
        expItem_t it;
        bit have;
        have = 0;
        if (d == 0) begin
            if (expQ0.size() > 0) begin it = expQ0.pop_front(); have = 1; end
        end else begin
            if (expQ1.size() > 0) begin it = expQ1.pop_front(); have = 1; end
        end
        checks++;
        if (!have) begin
            errors++;
            $display("[TB] FAIL unexpected_byte dut%0d: got %02h required none", d, rxByte[d]);
            dState[d] = 0;
        end else begin
            if (rxByte[d] !== it.b) begin
                errors++;
                $display("[TB] FAIL byte_value dut%0d: got %02h required %02h", d, rxByte[d], it.b);
            end
            checks++;
            if (stopVal[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stop_bit dut%0d: got %b required 1", d, stopVal[d]);
            end
            checks++;
            if (!widthOk[d]) begin
                errors++;
                $display("[TB] FAIL bit_width dut%0d: got unstable bit required %0d stable cycles", d, BPS);
            end
            if (it.last) begin
                dState[d] = 0;
            end else begin
                dState[d] = 2;
                gapCnt[d] = 0;
                curGap[d] = it.gap;
            end
        end
    endtask

    // UART line decoder sampled on the falling edge; also counts tx_done pulses
    always @(negedge sysClk) begin
        for (int d = 0; d < 2; d++) begin
            logic lineVal;
            if (txDone[d] === 1'b1) doneCnt[d]++;
            if (sysRstN !== 1'b1) begin
                dState[d] = 0;
            end else begin
                lineVal = uartTxd[d];
                if (dState[d] == 1) begin
                    if (cyc[d] == BPS) begin
                        bitIdx[d]++;
                        cyc[d] = 1;
                        bitVal[d] = lineVal;
                        if (bitIdx[d] >= 1 && bitIdx[d] <= 8) rxByte[d][bitIdx[d]-1] = lineVal;
                        else if (bitIdx[d] == 9) stopVal[d] = lineVal;
                        else finishByte(d);
                    end else begin
                        if (lineVal !== bitVal[d]) widthOk[d] = 0;
                        cyc[d]++;
                    end
                end
                if (dState[d] == 2) begin
                    if (lineVal === 1'b1) begin
                        gapCnt[d]++;
                    end else begin
                        checks++;
                        if (gapCnt[d] != curGap[d]) begin
                            errors++;
                            $display("[TB] FAIL byte_gap dut%0d: got %0d cycles required %0d", d, gapCnt[d], curGap[d]);
                        end
                        dState[d] = 0;
                    end
                end
                if (dState[d] == 0 && lineVal === 1'b0) begin
                    dState[d] = 1;
                    bitIdx[d] = 0;
                    cyc[d] = 1;
                    bitVal[d] = 1'b0;
                    widthOk[d] = 1;
                end
            end
        end
    end

    function automatic int frameCycles(input int d, input int len);
        int l;
        l = (len > MB) ? MB : len;
        return (l + 4) * 10 * BPS + ((d == 1) ? (l + 3) * BPS : 0);
    endfunction

    // Push the expected frame, then pulse tx_start for one cycle from the current time
    task automatic startFrame(input int d, input int len, input logic [MB*8-1:0] data);
        int l;
        int gap;
        logic [7:0] crc;
        logic [7:0] b;
        l = (len > MB) ? MB : len;
        gap = (d == 1) ? BPS : 0;
        crc = 8'h00;
        pushExp(d, 8'h55, gap, 0);
        pushExp(d, 8'hAA, gap, 0);
        pushExp(d, 8'(l), gap, 0);
        crc = crcModel(crc, 8'(l));
        for (int k = 0; k < l; k++) begin
            b = data[8*k +: 8];
            pushExp(d, b, gap, 0);
            crc = crcModel(crc, b);
        end
        pushExp(d, crc, 0, 1);
        txLen[d] = 8'(len);
        txData[d] = data;
        txStart[d] = 1'b1;
        @(posedge sysClk);
        #1;
        txStart[d] = 1'b0;
    endtask

    // Wait (bounded) for tx_done; check its timing, busy throughout and the scoreboard
    task automatic waitDone(input int d, input int expCycles, input int skew, input bit b2b);
        int cnt;
        int doneStart;
        bit seen;
        bit busyOk;
        cnt = skew;
        seen = 0;
        busyOk = 1;
        doneStart = doneCnt[d];
        while (cnt < expCycles + 50) begin
            if (txDone[d] === 1'b1) begin
                seen = 1;
                break;
            end
            if (txBusy[d] !== 1'b1) busyOk = 0;
            if (d == 0 && cnt == 25 * BPS) begin
                checks++;
                if (byteIdx[0] !== 8'd2) begin
                    errors++;
                    $display("[TB] FAIL byte_idx_len: got %0d required 2", byteIdx[0]);
                end
            end
            @(posedge sysClk);
            #1;
            cnt++;
        end
        checks++;
        if (!seen || cnt != expCycles) begin
            errors++;
            $display("[TB] FAIL done_time dut%0d: got %0d cycles (seen=%0d) required %0d", d, cnt, seen, expCycles);
        end
        checks++;
        if (!busyOk) begin
            errors++;
            $display("[TB] FAIL busy_hold dut%0d: got low during frame required high", d);
        end
        if (seen) begin
            checks++;
            if (txBusy[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_drop dut%0d: got %b required 0", d, txBusy[d]);
            end
        end
        if (!b2b) begin
            @(negedge sysClk);
            @(posedge sysClk);
            #1;
            checks++;
            if (((d == 0) ? expQ0.size() : expQ1.size()) != 0) begin
                errors++;
                $display("[TB] FAIL missing_bytes dut%0d: got %0d left required 0", d,
                         (d == 0) ? expQ0.size() : expQ1.size());
            end
            checks++;
            if (doneCnt[d] != doneStart + 1) begin
                errors++;
                $display("[TB] FAIL done_count dut%0d: got %0d required %0d", d, doneCnt[d] - doneStart, 1);
            end
        end
    endtask

    task automatic test_reset();
        sysRstN = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (uartTxd[d] !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd dut%0d: got %b required 1", d, uartTxd[d]); end
            checks++;
            if (txBusy[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy dut%0d: got %b required 0", d, txBusy[d]); end
            checks++;
            if (txDone[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done dut%0d: got %b required 0", d, txDone[d]); end
            checks++;
            if (byteIdx[d] !== 8'd0) begin errors++; $display("[TB] FAIL reset_idx dut%0d: got %0d required 0", d, byteIdx[d]); end
        end
        @(negedge sysClk);
        sysRstN = 1'b1;
        repeat (2) @(posedge sysClk);
    endtask

    task automatic test_basic();
        @(negedge sysClk);
        startFrame(0, 2, 96'h3412);
        checks++;
        if (uartTxd[0] !== 1'b0) begin errors++; $display("[TB] FAIL start_bit_latency: got %b required 0", uartTxd[0]); end
        waitDone(0, frameCycles(0, 2), 0, 0);
    endtask

    task automatic test_zero_len();
        @(negedge sysClk);
        startFrame(0, 0, 96'hDEAD);
        waitDone(0, frameCycles(0, 0), 0, 0);
    endtask

    task automatic test_clamp();
        @(negedge sysClk);
        startFrame(0, 20, 96'hF1E2D3C4B5A6978869504132);
        waitDone(0, frameCycles(0, 20), 0, 0);
    endtask

    task automatic test_ignore_busy();
        int n;
        int doneBefore;
        n = 35 * BPS;
        @(negedge sysClk);
        startFrame(0, 3, 96'hC3B2A1);
        repeat (n) begin @(posedge sysClk); #1; end
        txData[0] = {MB{8'hEE}};
        txLen[0] = 8'd9;
        txStart[0] = 1'b1;
        @(posedge sysClk);
        #1;
        txStart[0] = 1'b0;
        waitDone(0, frameCycles(0, 3), n + 1, 0);
        doneBefore = doneCnt[0];
        repeat (4) @(posedge sysClk);
        #1;
        checks++;
        if (txBusy[0] !== 1'b0 || doneCnt[0] != doneBefore) begin
            errors++;
            $display("[TB] FAIL busy_start_queued: got busy=%b extra_done=%0d required 0 0", txBusy[0], doneCnt[0] - doneBefore);
        end
    endtask

    task automatic test_reset_mid();
        int doneBefore;
        @(negedge sysClk);
        startFrame(0, 5, 96'h5544332211);
        repeat (63 * BPS) begin @(posedge sysClk); #1; end
        doneBefore = doneCnt[0];
        #2;
        sysRstN = 1'b0;
        #1;
        checks++;
        if (uartTxd[0] !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_txd: got %b required 1", uartTxd[0]); end
        checks++;
        if (txBusy[0] !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b required 0", txBusy[0]); end
        repeat (4) @(posedge sysClk);
        expQ0.delete();
        @(negedge sysClk);
        sysRstN = 1'b1;
        repeat (5) @(posedge sysClk);
        #1;
        checks++;
        if (doneCnt[0] != doneBefore || txBusy[0] !== 1'b0 || uartTxd[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abandoned_frame: got done=%0d busy=%b txd=%b required 0 0 1",
                     doneCnt[0] - doneBefore, txBusy[0], uartTxd[0]);
        end
        @(negedge sysClk);
        startFrame(0, 2, 96'h9A78);
        waitDone(0, frameCycles(0, 2), 0, 0);
    endtask

    task automatic test_back_to_back();
        int doneBefore;
        doneBefore = doneCnt[1];
        @(negedge sysClk);
        startFrame(1, 2, 96'hBEEF);
        waitDone(1, frameCycles(1, 2), 0, 1);
        @(posedge sysClk);
        #1;
        startFrame(1, 1, 96'h5A);
        waitDone(1, frameCycles(1, 1), 0, 0);
        checks++;
        if (doneCnt[1] != doneBefore + 2) begin
            errors++;
            $display("[TB] FAIL b2b_done_count: got %0d required 2", doneCnt[1] - doneBefore);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            txStart[d] = 1'b0;
            txLen[d] = 8'd0;
            txData[d] = '0;
            doneCnt[d] = 0;
            dState[d] = 0;
        end
        test_reset();
        test_basic();
        test_zero_len();
        test_clamp();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
